// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key schedule sequencer.
//   AES_NR     expansion rounds
//   AES_KB     bytes per round key
//   KS_DEPTH   bytes in the key schedule memory (cipher key + NR round keys)
//   RCON_LEAD  cycles by which round_counter leads a round's byte 0
//              (4-stage datapath delay plus the registered rcon ROM)
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_KB    = 16;
  localparam int KS_DEPTH  = 176;
  localparam int RCON_LEAD = 5;

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_LOAD,
    KS_EXPAND,
    KS_DONE
  } ks_state_t;

endpackage

// File: rtl/aes_key_schedule_ctrl_if.sv
// Host handshake and datapath/memory control bundle of the key schedule
// sequencer.
//   start, key_valid               host -> sequencer
//   key_ready, busy, done          sequencer -> host
//   en_generator, read_key_in, round_counter, encrypt, en_rcon,
//   en_rot_word, add_modified_last_word_to_r0, add_new_word_to_r4
//                                  sequencer -> byte-serial datapath
//   ks_mem_we, ks_mem_addr         sequencer -> key schedule memory
// The slave modport is the sequencer's view, master is the host/bench view.
interface aes_key_schedule_ctrl_if;

  logic       start;
  logic       key_valid;
  logic       key_ready;
  logic       en_generator;
  logic       read_key_in;
  logic [3:0] round_counter;
  logic       encrypt;
  logic       en_rcon;
  logic       en_rot_word;
  logic       add_modified_last_word_to_r0;
  logic       add_new_word_to_r4;
  logic       ks_mem_we;
  logic [7:0] ks_mem_addr;
  logic       busy;
  logic       done;

  modport slave (
    input  start, key_valid,
    output key_ready, en_generator, read_key_in, round_counter, encrypt,
           en_rcon, en_rot_word, add_modified_last_word_to_r0,
           add_new_word_to_r4, ks_mem_we, ks_mem_addr, busy, done
  );

  modport master (
    output start, key_valid,
    input  key_ready, en_generator, read_key_in, round_counter, encrypt,
           en_rcon, en_rot_word, add_modified_last_word_to_r0,
           add_new_word_to_r4, ks_mem_we, ks_mem_addr, busy, done
  );

endinterface

// File: rtl/aes_key_schedule_ctrl.sv
// Sequencer for the byte-serial AES-128 key schedule datapath.
// Loads the 16 cipher-key bytes, then expands forward for NR rounds of KB
// cycles, writing every round-key byte into the key schedule memory.
//   clk  clock
//   rst  synchronous active-high reset
//   ks   control bundle (slave modport), see aes_key_schedule_ctrl_if
//
// state      | meaning
// KS_IDLE    | waiting for start
// KS_LOAD    | accepting cipher-key bytes, stalls on key_valid gaps
// KS_EXPAND  | free-running expansion, one round-key byte per cycle
// KS_DONE    | single-cycle done pulse
module aes_key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int KB = AES_KB
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_key_schedule_ctrl_if.slave ks
);

  localparam logic [3:0] B_LAST    = 4'(KB - 1);
  localparam logic [3:0] R_LAST    = 4'(NR);
  // byte at which round_counter steps so the rcon ROM output lines up with
  // the next round's byte 0 after the datapath delay
  localparam logic [3:0] B_RC_STEP = 4'(KB - RCON_LEAD);
  // bytes 0..11 belong to words 0..2 of the new round key, which also feed r4
  localparam logic [3:0] B_NEW_END = 4'd11;
  localparam logic [3:0] B_ROT     = 4'd3;

  ks_state_t  state_q, state_d;
  logic [3:0] b_q, r_q, rc_q;
  logic       accept;

  logic key_ready, read_key_in, en_gen, mem_we;
  logic en_rcon, en_rot, add_mod, add_new, busy, done;

  assign accept = (state_q == KS_LOAD) && ks.key_valid;

  always_ff @(posedge clk) begin
    if (rst) state_q <= KS_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    key_ready   = 1'b0;
    read_key_in = 1'b0;
    en_gen      = 1'b0;
    mem_we      = 1'b0;
    en_rcon     = 1'b0;
    en_rot      = 1'b0;
    add_mod     = 1'b0;
    add_new     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      KS_IDLE: begin
        if (ks.start) state_d = KS_LOAD;
      end
      KS_LOAD: begin
        key_ready   = 1'b1;
        read_key_in = 1'b1;
        busy        = 1'b1;
        en_gen      = ks.key_valid;
        mem_we      = ks.key_valid;
        if (accept && b_q == B_LAST) state_d = KS_EXPAND;
      end
      KS_EXPAND: begin
        busy    = 1'b1;
        en_gen  = 1'b1;
        mem_we  = 1'b1;
        en_rcon = (b_q == 4'd0);
        en_rot  = (b_q == B_ROT);
        add_mod = (b_q <= B_ROT);
        add_new = (b_q <= B_NEW_END);
        if (b_q == B_LAST && r_q == R_LAST) state_d = KS_DONE;
      end
      KS_DONE: begin
        done    = 1'b1;
        state_d = KS_IDLE;
      end
      default: state_d = KS_IDLE;
    endcase
  end

  // b: byte within round key, r: round (0 = cipher key), rc: registered rcon index
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q  <= 4'd0;
      r_q  <= 4'd0;
      rc_q <= 4'd0;
    end else begin
      case (state_q)
        KS_LOAD: begin
          if (accept) begin
            // the rcon pipeline is free-running, so this step only lines up
            // if key_valid stays high for the last bytes of the load
            if (b_q == B_RC_STEP) rc_q <= r_q + 4'd1;
            if (b_q == B_LAST) begin
              b_q <= 4'd0;
              r_q <= 4'd1;
            end else begin
              b_q <= b_q + 4'd1;
            end
          end
        end
        KS_EXPAND: begin
          if (b_q == B_RC_STEP && r_q != R_LAST) rc_q <= r_q + 4'd1;
          if (b_q == B_LAST) begin
            b_q <= 4'd0;
            if (r_q == R_LAST) begin
              r_q  <= 4'd0;
              rc_q <= 4'd0;
            end else begin
              r_q <= r_q + 4'd1;
            end
          end else begin
            b_q <= b_q + 4'd1;
          end
        end
        default: begin
          b_q  <= 4'd0;
          r_q  <= 4'd0;
          rc_q <= 4'd0;
        end
      endcase
    end
  end

  assign ks.key_ready                    = key_ready;
  assign ks.read_key_in                  = read_key_in;
  assign ks.en_generator                 = en_gen;
  assign ks.ks_mem_we                    = mem_we;
  assign ks.ks_mem_addr                  = 8'(r_q) * 8'(KB) + 8'(b_q);
  assign ks.round_counter                = rc_q;
  // expansion is always forward; decryption reads the memory in reverse
  assign ks.encrypt                      = 1'b1;
  assign ks.en_rcon                      = en_rcon;
  assign ks.en_rot_word                  = en_rot;
  assign ks.add_modified_last_word_to_r0 = add_mod;
  assign ks.add_new_word_to_r4           = add_new;
  assign ks.busy                         = busy;
  assign ks.done                         = done;

endmodule
